// File: rtl/lsu_mem_initiator_pkg.sv
// Shared encodings for the load/store unit: MMU widths, RV32I funct3 values,
// fault causes, FSM states and the captured bus request payload.
package lsu_mem_initiator_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] MMU_WIDTH_BYTE = 2'd0;
    localparam logic [1:0] MMU_WIDTH_HALF = 2'd1;
    localparam logic [1:0] MMU_WIDTH_WORD = 2'd3;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [2:0] CAUSE_NONE       = 3'd0;
    localparam logic [2:0] CAUSE_LOAD_MISAL = 3'd1;
    localparam logic [2:0] CAUSE_STORE_MISAL = 3'd2;
    localparam logic [2:0] CAUSE_ILLEGAL    = 3'd3;
    localparam logic [2:0] CAUSE_TIMEOUT    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [1:0]      width;
        logic            is_signed;
        logic            store;
    } bus_req_t;

    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic [1:0] f3_width(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return MMU_WIDTH_BYTE;
            2'd1:    return MMU_WIDTH_HALF;
            default: return MMU_WIDTH_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lo);
        return ((width == MMU_WIDTH_HALF) && lo[0]) ||
               ((width == MMU_WIDTH_WORD) && (lo != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select and sign/zero extension from a raw aligned word.
module lsu_load_align
    import lsu_mem_initiator_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = word_i[{addr_lo_i, 3'b000} +: 8];
        half_c = word_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_c[7]}}, byte_c};
            F3_BU:   data_o = {24'd0, byte_c};
            F3_H:    data_o = {{16{half_c[15]}}, half_c};
            F3_HU:   data_o = {16'd0, half_c};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store unit initiator: decodes one RV32I access, drives the MMU handshake,
// extracts load data and returns a single-cycle response.
module lsu_mem_initiator
    import lsu_mem_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned MMU_EXTRACTS   = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_base,
    input  logic [XLEN-1:0] req_offset,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [2:0]      resp_cause,
    output logic            mem_read_enable,
    output logic            mem_write_enable,
    output logic            mem_signed_read,
    output logic [1:0]      mem_data_width,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_data_in,
    input  logic [XLEN-1:0] mem_data_out,
    input  logic            mem_ready
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

    lsu_state_e      state_q, state_d;
    bus_req_t        bus_q, bus_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            resp_fault_q, resp_fault_d;
    logic [2:0]      resp_cause_q, resp_cause_d;
    logic            rd_en_q, rd_en_d;
    logic            wr_en_q, wr_en_d;

    logic [XLEN-1:0] ea_c;
    logic [1:0]      width_c;
    logic [XLEN-1:0] aligned_c;
    logic [XLEN-1:0] load_result_c;

    assign ea_c    = req_base + req_offset;
    assign width_c = f3_width(req_funct3);

    lsu_load_align u_align (
        .word_i    (mem_data_out),
        .addr_lo_i (bus_q.addr[1:0]),
        .funct3_i  (funct3_q),
        .data_o    (aligned_c)
    );

    assign load_result_c = (MMU_EXTRACTS != 0) ? mem_data_out : aligned_c;

    // Next-state, capture and response logic
    always_comb begin
        state_d      = state_q;
        bus_d        = bus_q;
        funct3_d     = funct3_q;
        cnt_d        = cnt_q;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        resp_cause_d = resp_cause_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    bus_d.addr      = ea_c;
                    bus_d.wdata     = req_wdata;
                    bus_d.width     = width_c;
                    bus_d.is_signed = !req_store && ((req_funct3 == F3_B) || (req_funct3 == F3_H));
                    bus_d.store     = req_store;
                    funct3_d        = req_funct3;
                    resp_rdata_d    = '0;
                    if (!f3_legal(req_store, req_funct3)) begin
                        state_d      = ST_RESP;
                        resp_fault_d = 1'b1;
                        resp_cause_d = CAUSE_ILLEGAL;
                    end else if (is_misaligned(width_c, ea_c[1:0])) begin
                        state_d      = ST_RESP;
                        resp_fault_d = 1'b1;
                        resp_cause_d = req_store ? CAUSE_STORE_MISAL : CAUSE_LOAD_MISAL;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d      = ST_RESP;
                    resp_rdata_d = bus_q.store ? '0 : load_result_c;
                    resp_fault_d = 1'b0;
                    resp_cause_d = CAUSE_NONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == TIMEOUT_CNT) begin
                        state_d      = ST_RESP;
                        resp_rdata_d = '0;
                        resp_fault_d = 1'b1;
                        resp_cause_d = CAUSE_TIMEOUT;
                    end
                end
            end
            ST_RESP: begin
                state_d      = ST_IDLE;
                resp_rdata_d = '0;
                resp_fault_d = 1'b0;
                resp_cause_d = CAUSE_NONE;
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        rd_en_d      = (state_d == ST_ISSUE) && !bus_d.store;
        wr_en_d      = (state_d == ST_ISSUE) &&  bus_d.store;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bus_q        <= '0;
            funct3_q     <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
            resp_cause_q <= CAUSE_NONE;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_q        <= bus_d;
            funct3_q     <= funct3_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            resp_cause_q <= resp_cause_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_rdata       = resp_rdata_q;
    assign resp_fault       = resp_fault_q;
    assign resp_cause       = resp_cause_q;
    assign mem_read_enable  = rd_en_q;
    assign mem_write_enable = wr_en_q;
    assign mem_signed_read  = bus_q.is_signed;
    assign mem_data_width   = bus_q.width;
    assign mem_address      = bus_q.addr;
    assign mem_data_in      = bus_q.wdata;

endmodule
